uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver. Oversamples the serial line with a 3-sample majority vote and supports
//  configurable data width, parity mode and stop-bit count. Delivers each word over a valid/ready
//  handshake with parity, framing and overrun status. Feeds the UART RX datapath; its own tick
//  generator replaces the fixed F/8 baud clock.
// PARAMETERS
//  DATA_W      8   data bits per frame, legal 5..9, LSB first
//  OVERSAMPLE  16  samples per bit, even, >=8
//  BAUD_DIV    4   i_clk cycles per oversample tick, >=2
//  PARITY      1   0 none, 1 even, 2 odd
//  STOP_BITS   1   1 or 2
// PORTS
//  i_clk         in   1       system clock
//  i_reset       in   1       asynchronous, active-low reset
//  i_rxd         in   1       serial line, idle high, asynchronous to i_clk
//  i_ready       in   1       consumer accepts o_data when o_valid=1
//  o_data        out  DATA_W  received word
//  o_valid       out  1       o_data and error flags valid; held until accepted
//  o_parity_err  out  1       parity mismatch on held word (0 when PARITY=0)
//  o_frame_err   out  1       any stop bit sampled 0 on held word
//  o_overrun     out  1       1-cycle pulse: completed frame dropped
//  o_busy        out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, synchroniser flops 1, edge register 0.
//  - i_rxd passes through 2-flop synchroniser. Start detection needs synced line seen high, then low,
//    so a line held low across reset release is ignored until it returns high.
//  - Tick counter 0..BAUD_DIV-1 pulses tick on terminal count. Held at 0 in IDLE, so it is aligned
//    to the start edge. Sample counter 0..OVERSAMPLE-1 advances per tick.
//  - Bit value: majority of synced samples at sample indices M-1, M, M+1, where M=OVERSAMPLE/2.
//    It is decided at the M+1 tick.
//  - FSM: IDLE -> START on falling edge.
//    START: voted 1 -> IDLE (false start, no output); voted 0 -> DATA.
//    DATA: DATA_W bits shifted LSB first -> PARITY (PARITY!=0) else STOP.
//    PARITY: store the voted bit.
//    STOP: STOP_BITS bits; any 0 sets frame error.
//    After the last stop-bit decision -> IDLE immediately. This gives half-bit resync margin, and
//    back-to-back frames are accepted.
//  - Parity: even means XOR(data, parity bit)=0; odd means it equals 1.
//  - Completion: 1 i_clk after the last stop decision, o_data/o_parity_err/o_frame_err load and
//    o_valid=1. Errored frames are still delivered with the flags set.
//  - Handshake: the transfer occurs on a cycle with o_valid & i_ready. o_valid drops the next cycle
//    unless a new word loads in that same cycle.
//  - Completion while o_valid=1 and i_ready=0: the held word and flags are unchanged, the new word is
//    discarded, and o_overrun=1 for one cycle.
//  - Completion in the same cycle as acceptance: the new word loads, o_valid stays 1, no overrun.
//  - Reset asserted mid-frame aborts at once: partial word is lost, all outputs return to reset values.
//  - Frame length in i_clk = BAUD_DIV*OVERSAMPLE*(2+DATA_W+(PARITY!=0)+STOP_BITS-1).
// CONFIGURATION
//  UART_RX_BREAK_EN defined:
//   - Adds port o_break (out, 1).
//   - A frame with all data bits 0, parity (if present) 0 and first stop bit 0 gives a 1-cycle
//     o_break pulse at completion time instead of loading o_data/o_valid.
//   - FSM then waits in IDLE for the synced line to go high before a new start is accepted.
//  UART_RX_BREAK_EN undefined:
//   - No o_break port. Such a frame is delivered normally as data 0 with o_frame_err=1.
// TESTING (DATA_W=8, OVERSAMPLE=16, BAUD_DIV=4, PARITY=1, STOP_BITS=1; 64 i_clk/bit)
//  - Frame 0xA5 with parity 0 and stop 1, i_ready=1 -> o_data=8'hA5 and o_valid for 1 cycle,
//    ~(11*64 - 32 + sync) clk after start edge; both error flags 0.
//  - Frame 0x3C with parity bit 1 -> o_data=8'h3C, o_parity_err=1. Next frame 0x3C with
//    stop=0 -> o_frame_err=1, o_parity_err=0.
//  - Low glitch of 20 clk on idle line -> START rejects it, o_busy returns 0, no o_valid.
//  - i_ready=0; frames 0x11 then 0x22 back-to-back -> o_data stays 8'h11, o_overrun pulses once
//    at the second completion. Then i_ready=1 -> 0x11 accepted, o_valid falls.
//  - Single-sample inversion at mid-sample of each data bit of 0xF0 -> majority still
//    yields 8'hF0.
//  - i_reset low for 3 clk mid-DATA, then a clean 0x5A frame -> all outputs 0 during reset,
//    next word is 8'h5A. With UART_RX_BREAK_EN, an all-zero 11-bit line gives o_break=1 and
//    no o_valid.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote, parity/framing/overrun status.
// Define UART_RX_BREAK_EN to report break frames on o_break instead of delivering them.
module uart_rx_param #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 4,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rxd,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun,
`ifdef UART_RX_BREAK_EN
    output logic              o_break,
`endif
    output logic              o_busy
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int TW = $clog2(BAUD_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state;
    logic              sync1, sync2, line_prev;
    logic [1:0]        warm;
    logic [TW-1:0]     tick_cnt;
    logic [SW-1:0]     samp_cnt;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit, ferr, samp_a, samp_b, done;
    logic              tick, decide, vote, fall, perr, brk;

    assign tick   = (state != IDLE) && (tick_cnt == TW'(BAUD_DIV - 1));
    assign decide = tick && (samp_cnt == SW'(M + 1));
    assign vote   = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
    assign fall   = line_prev & ~sync2;
    assign perr   = (PARITY == 1) ? ^{shreg, par_bit} : (PARITY == 2) ? ~^{shreg, par_bit} : 1'b0;
    assign o_busy = state != IDLE;

`ifdef UART_RX_BREAK_EN
    logic stop0;
    assign brk = ~|shreg & ((PARITY == 0) | ~par_bit) & stop0;
`else
    assign brk = 1'b0;
`endif

    // Edge register only trusts the line once the synchroniser holds real samples,
    // so a line held low through reset release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            warm      <= '0;
            line_prev <= 1'b0;
        end else begin
            sync1     <= i_rxd;
            sync2     <= sync1;
            warm      <= {warm[0], 1'b1};
            line_prev <= warm[1] & sync2;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr     <= 1'b0;
            samp_a   <= 1'b0;
            samp_b   <= 1'b0;
            done     <= 1'b0;
`ifdef UART_RX_BREAK_EN
            stop0    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= '0;
                samp_cnt <= '0;
                if (fall) state <= START;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
                    if (samp_cnt == SW'(M - 1)) samp_a <= sync2;
                    if (samp_cnt == SW'(M)) samp_b <= sync2;
                end
                if (decide) begin
                    case (state)
                        START: begin
                            state   <= vote ? IDLE : DATA;
                            bit_cnt <= '0;
                            ferr    <= 1'b0;
                        end
                        DATA: begin
                            shreg   <= {vote, shreg[DATA_W-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CW'(DATA_W - 1)) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != 0) ? PAR : STOP;
                            end
                        end
                        PAR: begin
                            par_bit <= vote;
                            state   <= STOP;
                        end
                        STOP: begin
                            ferr    <= ferr | ~vote;
`ifdef UART_RX_BREAK_EN
                            if (bit_cnt == '0) stop0 <= ~vote;
`endif
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CW'(STOP_BITS - 1)) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    // A held, unaccepted word wins over a newly completed one.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef UART_RX_BREAK_EN
            o_break      <= 1'b0;
`endif
        end else begin
            o_overrun <= 1'b0;
`ifdef UART_RX_BREAK_EN
            o_break   <= done & brk;
`endif
            if (o_valid && i_ready) o_valid <= 1'b0;
            if (done && !brk) begin
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_data       <= shreg;
                    o_parity_err <= perr;
                    o_frame_err  <= ferr;
                    o_valid      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized and directed frames checked against a word-level receive model.
module tb_uart_rx_param;
    logic       i_clk = 1'b0, i_reset = 1'b0, i_rxd = 1'b1, i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;
    int         n_chk = 0, n_err = 0, ov_cnt = 0, exp_ov = 0;
    logic [9:0] got_q[$], exp_q[$];
    logic [9:0] slot;
    bit         slot_full = 0;
`ifdef UART_RX_BREAK_EN
    logic o_break;
    int   brk_cnt = 0, exp_brk = 0;
`endif

    uart_rx_param dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rxd(i_rxd), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_parity_err(o_parity_err),
        .o_frame_err(o_frame_err), .o_overrun(o_overrun),
`ifdef UART_RX_BREAK_EN
        .o_break(o_break),
`endif
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Every cycle with o_valid & i_ready is one delivered word.
    always @(negedge i_clk) begin
        if (i_reset && o_valid && i_ready) got_q.push_back({o_data, o_parity_err, o_frame_err});
        if (o_overrun) ov_cnt++;
`ifdef UART_RX_BREAK_EN
        if (o_break) brk_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        for (int c = 0; c < 64; c++) begin
            i_rxd = (glitch && c >= 35 && c <= 37) ? ~v : v;
            step();
        end
    endtask

    // Word-level model: even parity, stop bit, single holding slot.
    task automatic model_complete(input logic [7:0] d, input logic pb, input logic sb);
        logic [9:0] w;
        w = {d, ^{d, pb}, ~sb};
`ifdef UART_RX_BREAK_EN
        if (d == 8'h00 && !pb && !sb) begin
            exp_brk++;
            return;
        end
`endif
        if (i_ready) begin
            if (slot_full) exp_q.push_back(slot);
            exp_q.push_back(w);
            slot_full = 0;
        end else if (slot_full) begin
            exp_ov++;
        end else begin
            slot = w;
            slot_full = 1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad, input logic sb,
                              input bit glitch, input int gap);
        logic pb;
        pb = ^d ^ bad;
        drive_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
        drive_bit(pb, 0);
        drive_bit(sb, 0);
        i_rxd = 1'b1;
        step(gap);
        model_complete(d, pb, sb);
    endtask

    task automatic compare_q(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        while (got_q.size() != 0 && exp_q.size() != 0)
            check({tag, " word"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, " overrun"}, ov_cnt, exp_ov);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge i_clk);
        check(tag, {o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy}, '0);
    endtask

    initial begin
        step(2);
        check_reset_outputs("reset state");
        i_reset = 1'b1;
        step(8);
        send_frame(8'hA5, 0, 1'b1, 0, 8);
        compare_q("frame A5");
        send_frame(8'h3C, 1, 1'b1, 0, 8);
        compare_q("parity err");
        send_frame(8'h3C, 0, 1'b0, 0, 10);
        compare_q("frame err");
        i_rxd = 1'b0;
        step(10);
        @(negedge i_clk);
        check("glitch busy", o_busy, 1'b1);
        step(10);
        i_rxd = 1'b1;
        step(60);
        @(negedge i_clk);
        check("glitch idle", o_busy, 1'b0);
        compare_q("glitch");
        send_frame(8'hF0, 0, 1'b1, 1, 8);
        compare_q("majority F0");
        i_ready = 1'b0;
        send_frame(8'h11, 0, 1'b1, 0, 0);
        send_frame(8'h22, 0, 1'b1, 0, 8);
        @(negedge i_clk);
        check("held data", o_data, 8'h11);
        check("held valid", o_valid, 1'b1);
        compare_q("overrun");
        step();
        i_ready = 1'b1;
        if (slot_full) exp_q.push_back(slot);
        slot_full = 0;
        step();
        @(negedge i_clk);
        check("valid falls", o_valid, 1'b0);
        compare_q("accept");
        i_ready = 1'b0;
        send_frame(8'hC3, 0, 1'b1, 0, 8);
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b1, 0);
        i_rxd = 1'b1;
        i_reset = 1'b0;
        slot_full = 0;
        for (int i = 0; i < 3; i++) begin
            check_reset_outputs("mid-frame reset");
            step();
        end
        i_reset = 1'b1;
        i_ready = 1'b1;
        step(10);
        send_frame(8'h5A, 0, 1'b1, 0, 8);
        compare_q("after reset");
`ifdef UART_RX_BREAK_EN
        send_frame(8'h00, 0, 1'b0, 0, 10);
        check("break pulse", brk_cnt, exp_brk);
        compare_q("break");
`endif
        for (int n = 0; n < 10; n++) begin
            logic [7:0] d;
            logic       sb;
            d  = 8'($urandom);
            sb = $urandom_range(0, 3) != 0;
            send_frame(d, $urandom_range(0, 3) == 0, sb, bit'($urandom_range(0, 1)),
                       sb ? $urandom_range(0, 12) : $urandom_range(8, 16));
            compare_q("random");
        end
`ifdef UART_RX_BREAK_EN
        check("break total", brk_cnt, exp_brk);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
